// File: rtl/inv_sbytes_top.sv
// AES InvSubBytes controller: walks the 16 state bytes in SRAM, substitutes
// each one through the inverse S-box and writes it back in place.
//
//   state | meaning
//   IDLE  | no requests; waits for inv_sbytes_enable
//   LOAD  | read request for byte_idx, held until mem_ready
//   CALC  | new_byte <= InvSbox(old_byte)
//   SAVE  | write request of new_byte to byte_idx, held until mem_ready
//   DONE  | one-cycle finished pulse, byte_idx cleared
module inv_sbytes_top #(
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              inv_sbytes_enable,
  output logic              inv_sbytes_finished,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, SAVE, DONE} state_t;

  // FIPS-197 inverse S-box, indexed by the input byte.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  state_t     state, state_nxt;
  logic [3:0] byte_idx;
  logic [7:0] old_byte;
  logic [7:0] new_byte;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (inv_sbytes_enable) state_nxt = LOAD;
      LOAD: if (mem_ready) state_nxt = CALC;
      CALC: state_nxt = SAVE;
      SAVE: if (mem_ready) state_nxt = (byte_idx == 4'd15) ? DONE : LOAD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_idx <= 4'd0;
      old_byte <= 8'h00;
      new_byte <= 8'h00;
    end else begin
      case (state)
        IDLE: if (inv_sbytes_enable) byte_idx <= 4'd0;
        LOAD: if (mem_ready) old_byte <= mem_rdata;
        CALC: new_byte <= INV_SBOX[old_byte];
        SAVE: if (mem_ready && byte_idx != 4'd15) byte_idx <= byte_idx + 4'd1;
        DONE: byte_idx <= 4'd0;
        default: ;
      endcase
    end
  end

  // Outputs depend only on registered state so no SRAM/enable path reaches them.
  assign mem_read            = (state == LOAD);
  assign mem_write           = (state == SAVE);
  assign mem_wdata           = (state == SAVE) ? new_byte : 8'h00;
  assign inv_sbytes_finished = (state == DONE);
  assign mem_addr            = ADDR_W'(BASE_ADDR) + ADDR_W'(byte_idx);

endmodule

// File: tb/tb_inv_sbytes_top.sv
// Bench for inv_sbytes_top: behavioural SRAM with programmable wait states,
// expected values from hand tables and from an inverse built off the forward S-box.
module tb_inv_sbytes_top;

  localparam int BASE   = 'h0100;
  localparam int ADDR_W = 16;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              enable;
  logic              finished;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  int         checks = 0;
  int         errors = 0;
  int         wait_n = 0;
  logic [7:0] mem [16];
  logic [7:0] inv_m [256];
  vec_t       vecs [16];

  always #5 clk = ~clk;

  inv_sbytes_top #(.BASE_ADDR(BASE), .ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .inv_sbytes_enable   (enable),
    .inv_sbytes_finished (finished),
    .mem_addr            (mem_addr),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .mem_ready           (mem_ready)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // SRAM model: decides mem_ready on the falling edge, commits writes then.
  initial begin : mem_model
    int                cnt;
    bit                fresh;
    int                last_w;
    int                idx;
    logic [ADDR_W-1:0] s_addr;
    logic              s_rd;
    logic [7:0]        s_wd;
    cnt = 0; fresh = 1'b1; last_w = -1; idx = 0;
    s_addr = '0; s_rd = 1'b0; s_wd = 8'h00;
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        mem_ready = 1'b0;
        fresh     = 1'b1;
        last_w    = -1;
      end else if (mem_read || mem_write) begin
        chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
        idx = int'(mem_addr) - BASE;
        chk("addr_range", 32'(idx >= 0 && idx < 16), 32'd1);
        if (fresh) begin
          cnt = wait_n; s_addr = mem_addr; s_rd = mem_read; s_wd = mem_wdata;
          fresh = 1'b0;
        end else begin
          chk("stall_addr", 32'(mem_addr), 32'(s_addr));
          chk("stall_kind", 32'(mem_read), 32'(s_rd));
          chk("stall_wdata", 32'(mem_wdata), 32'(s_wd));
        end
        if (cnt > 0) begin
          cnt--;
          mem_ready = 1'b0;
        end else begin
          mem_ready = 1'b1;
          fresh     = 1'b1;
          if (mem_read) begin
            mem_rdata = mem[idx[3:0]];
          end else begin
            chk("write_order", 32'(idx), 32'((last_w == 15) ? 0 : last_w + 1));
            last_w = idx;
            mem[idx[3:0]] = mem_wdata;
          end
        end
      end else begin
        mem_ready = 1'b0;
        fresh     = 1'b1;
      end
    end
  end

  // Start on the next edge; hold enable for 'passes' passes (or pulse it when passes==1).
  task automatic run_pass(input int waits, input int passes);
    int per, seen, last, limit;
    per = 48 + 32 * waits;
    seen = 0; last = 0;
    limit = passes * (per + 2) + 10;
    wait_n = waits;
    enable = 1'b1;
    @(posedge clk); #1;
    if (passes == 1) enable = 1'b0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(posedge clk); #1;
      if (finished) begin
        seen++;
        last = cyc;
        chk("finish_cycle", 32'(cyc), 32'(per + (seen - 1) * (per + 2)));
        if (seen >= passes) enable = 1'b0;
      end
      if (seen >= passes && cyc >= last + 2) break;
    end
    chk("finish_count", 32'(seen), 32'(passes));
    chk("idle_after_pass", 32'({mem_read, mem_write, finished}), 32'd0);
    wait_n = 0;
  endtask

  task automatic load_vecs();
    for (int i = 0; i < 16; i++) mem[i] = vecs[i].din;
  endtask

  initial begin
    bit found;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) inv_m[SBOX[i]] = 8'(i);

    vecs[0]  = '{8'h63, 8'h00}; vecs[1]  = '{8'h7C, 8'h01};
    vecs[2]  = '{8'h00, 8'h52}; vecs[3]  = '{8'h16, 8'hFF};
    vecs[4]  = '{8'hED, 8'h53}; vecs[5]  = '{8'h52, 8'h48};
    vecs[6]  = '{8'h53, 8'h50}; vecs[7]  = '{8'h54, 8'hFD};
    vecs[8]  = '{8'h55, 8'hED}; vecs[9]  = '{8'h56, 8'hB9};
    vecs[10] = '{8'h57, 8'hDA}; vecs[11] = '{8'h58, 8'h5E};
    vecs[12] = '{8'h59, 8'h15}; vecs[13] = '{8'h5A, 8'h46};
    vecs[14] = '{8'h5B, 8'h57}; vecs[15] = '{8'h5C, 8'hA7};

    n_rst = 1'b0; enable = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    // packed {finished, read, write, wdata, addr}: only addr nonzero
    chk("reset_outputs", 32'({finished, mem_read, mem_write, mem_wdata, mem_addr}), 32'(BASE));
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_outputs", 32'({finished, mem_read, mem_write, mem_wdata, mem_addr}), 32'(BASE));
    end

    load_vecs();
    run_pass(0, 1);
    for (int i = 0; i < 16; i++) chk($sformatf("zero_wait_b%0d", i), 32'(mem[i]), 32'(vecs[i].dout));

    load_vecs();
    run_pass(2, 1);
    for (int i = 0; i < 16; i++) chk($sformatf("wait2_b%0d", i), 32'(mem[i]), 32'(vecs[i].dout));

    load_vecs();
    run_pass(0, 2);
    chk("twice_b0_hand", 32'(mem[0]), 32'h52);
    for (int i = 0; i < 16; i++)
      chk($sformatf("twice_b%0d", i), 32'(mem[i]), 32'(inv_m[vecs[i].dout]));

    load_vecs();
    found = 1'b0;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (mem_write && mem_addr == ADDR_W'(BASE + 5)) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_save_b5", 32'(found), 32'd1);
    n_rst = 1'b0;
    #1;
    chk("reset_mid_drop", 32'({finished, mem_read, mem_write, mem_wdata, mem_addr}), 32'(BASE));
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mid_hold", 32'({finished, mem_read, mem_write, mem_wdata, mem_addr}), 32'(BASE));
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++)
      chk($sformatf("reset_mid_b%0d", i), 32'(mem[i]), 32'((i < 5) ? vecs[i].dout : vecs[i].din));
    load_vecs();
    run_pass(0, 1);
    for (int i = 0; i < 16; i++) chk($sformatf("after_rst_b%0d", i), 32'(mem[i]), 32'(vecs[i].dout));

    for (int p = 0; p < 16; p++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'(p * 16 + i);
      run_pass(0, 1);
      for (int i = 0; i < 16; i++) begin
        v = 8'(p * 16 + i);
        chk($sformatf("rom_%02h", v), 32'(mem[i]), 32'(inv_m[v]));
        chk($sformatf("fwd_round_%02h", v), 32'(SBOX[mem[i]]), 32'(v));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
